// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-lite initiator: command/response front end, fully
// registered bus side, sticky watchdog for a stalled slave.
module axi_lite_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int C_TIMEOUT          = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]                   cmd_wdata,
   input  logic [3:0]                    cmd_wstrb,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_write,
   output logic [31:0]                   rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          busy,
   output logic                          timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [31:0]                   M_AXI_WDATA,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [31:0]                   M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(C_TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDRDATA,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RESP
   } state_t;

   state_t                          state_q, state_d;
   logic                            cmd_ready_q, cmd_ready_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]                     wdata_q, wdata_d;
   logic [3:0]                      wstrb_q, wstrb_d;
   logic                            awvalid_q, awvalid_d;
   logic                            wvalid_q, wvalid_d;
   logic                            bready_q, bready_d;
   logic                            arvalid_q, arvalid_d;
   logic                            rready_q, rready_d;
   logic                            rsp_valid_q, rsp_valid_d;
   logic                            rsp_write_q, rsp_write_d;
   logic [31:0]                     rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                      rsp_resp_q, rsp_resp_d;
   logic                            busy_q, busy_d;
   logic                            timeout_q, timeout_d;
   logic [15:0]                     wd_q, wd_d;
   logic                            stall;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      timeout_d   = timeout_q;
      wd_d        = wd_q;
      stall       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               wd_d      = '0;
               timeout_d = 1'b0;
               if (cmd_write) begin
                  state_d   = ST_WR_ADDRDATA;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_WR_ADDRDATA: begin
            // AW and W retire independently; leave once neither is still pending
            if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
            if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (M_AXI_BVALID) begin
               state_d     = ST_RESP;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = M_AXI_BRESP;
            end else begin
               stall = 1'b1;
            end
         end
         ST_RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               state_d   = ST_RD_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         ST_RD_DATA: begin
            if (M_AXI_RVALID) begin
               state_d     = ST_RESP;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = M_AXI_RDATA;
               rsp_resp_d  = M_AXI_RRESP;
            end else begin
               stall = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (stall && (wd_q != '1)) wd_d = wd_q + 16'd1;
      if (wd_d >= TIMEOUT_LIMIT) timeout_d = 1'b1;
   end

   assign cmd_ready_d = (state_d == ST_IDLE);
   assign busy_d      = (state_d != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         wd_q        <= wd_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign busy          = busy_q;
   assign timeout       = timeout_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-programmable AXI4-lite slave model, expected
// responses queued at command time and compared when the response handshakes.
module tb_axi_lite_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        busy, timeout;
   logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic        M_AXI_AWVALID, M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY;
   logic        M_AXI_ARVALID, M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   axi_lite_master #(.C_M_AXI_ADDR_WIDTH(4), .C_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // slave model configuration, written only by the main sequence
   int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [31:0] rdata_cfg = '0;
   logic [1:0]  rresp_cfg = '0, bresp_cfg = '0;
   int          n_b = 0, n_rsp = 0;

   typedef struct {
      logic        wr;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;
   exp_t sb[$];

   initial begin
      int unsigned aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic aw_got = 1'b0, w_got = 1'b0, b_arm = 1'b0, r_arm = 1'b0;
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
      M_AXI_BVALID = 1'b0; M_AXI_BRESP = '0;
      M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'hDEADBEEF; M_AXI_RRESP = '0;
      forever begin
         @(negedge clk);
         aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
         w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
         b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
         ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
         r_hs  = M_AXI_RVALID  && M_AXI_RREADY;
         if (aw_hs) aw_got = 1'b1;
         if (w_hs)  w_got  = 1'b1;
         if (b_hs)  n_b++;
         @(posedge clk); #1;
         if (M_AXI_AWVALID) begin
            M_AXI_AWREADY = (aw_wait >= aw_delay);
            if (!M_AXI_AWREADY) aw_wait++;
         end else begin M_AXI_AWREADY = 1'b0; aw_wait = 0; end
         if (M_AXI_WVALID) begin
            M_AXI_WREADY = (w_wait >= w_delay);
            if (!M_AXI_WREADY) w_wait++;
         end else begin M_AXI_WREADY = 1'b0; w_wait = 0; end
         if (M_AXI_ARVALID) begin
            M_AXI_ARREADY = (ar_wait >= ar_delay);
            if (!M_AXI_ARREADY) ar_wait++;
         end else begin M_AXI_ARREADY = 1'b0; ar_wait = 0; end
         if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; b_arm = 1'b1; b_wait = 0; end
         if (b_hs) M_AXI_BVALID = 1'b0;
         if (b_arm) begin
            if (b_wait >= b_delay) begin
               M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp_cfg; b_arm = 1'b0;
            end else b_wait++;
         end
         if (ar_hs) begin r_arm = 1'b1; r_wait = 0; end
         if (r_hs) begin M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'hDEADBEEF; end
         if (r_arm) begin
            if (r_wait >= r_delay) begin
               M_AXI_RVALID = 1'b1; M_AXI_RDATA = rdata_cfg; M_AXI_RRESP = rresp_cfg; r_arm = 1'b0;
            end else r_wait++;
         end
      end
   end

   // response side of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
               check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("rsp_write", {31'd0, rsp_write}, {31'd0, e.wr});
               check("rsp_rdata", rsp_rdata, e.data);
               check("rsp_resp",  {30'd0, rsp_resp}, {30'd0, e.resp});
            end
         end
      end
   end

   task automatic push_exp(input logic wr);
      exp_t e;
      e.wr   = wr;
      e.data = wr ? 32'd0 : rdata_cfg;
      e.resp = wr ? bresp_cfg : rresp_cfg;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // returns #1 after the accept edge (cycle 1 of the transaction)
   task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int unsigned n = 0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 50) begin step(); n++; end
      if (!cmd_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 300) begin step(); n++; end
      if (sb.size() != 0) begin
         check("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      step();
   endtask

   initial begin
      int b0, r0;
      logic [3:0] ra;
      logic rw;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;

      // reset state
      step(); step();
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_busy",      {31'd0, busy}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_timeout",   {31'd0, timeout}, 32'd0);
      check("rst_valids",    {29'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 32'd0);
      reset = 1'b0;
      step();
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // zero-wait write
      bresp_cfg = 2'd0;
      push_exp(1'b1);
      send_cmd(1'b1, 4'h8, 32'h0000_0005, 4'hF);
      check("w0_c1_valids", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
      check("w0_c1_awaddr", {28'd0, M_AXI_AWADDR}, 32'h8);
      check("w0_c1_wdata",  M_AXI_WDATA, 32'h5);
      check("w0_c1_wstrb",  {28'd0, M_AXI_WSTRB}, 32'hF);
      check("w0_c1_prot",   {26'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
      check("w0_c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      step();
      check("w0_c2_bready", {31'd0, M_AXI_BREADY}, 32'd1);
      check("w0_c2_valids", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
      step();
      check("w0_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      drain();

      // skewed write handshakes: WREADY 3 cycles after AWREADY
      w_delay = 3;
      b0 = n_b; r0 = n_rsp;
      push_exp(1'b1);
      send_cmd(1'b1, 4'h0, 32'h0000_0005, 4'hF);
      step();
      check("ws_c2_awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);
      check("ws_c2_wvalid",  {31'd0, M_AXI_WVALID}, 32'd1);
      check("ws_c2_bready",  {31'd0, M_AXI_BREADY}, 32'd0);
      step(); step();
      check("ws_c4_wvalid",  {31'd0, M_AXI_WVALID}, 32'd1);
      check("ws_c4_wdata",   M_AXI_WDATA, 32'h5);
      drain();
      check("ws_b_count",   32'(n_b - b0), 32'd1);
      check("ws_rsp_count", 32'(n_rsp - r0), 32'd1);
      w_delay = 0;

      // read with 4 wait states on RVALID, SLVERR passed through
      r_delay = 4; rdata_cfg = 32'hE000_0003; rresp_cfg = 2'd2;
      push_exp(1'b0);
      send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
      check("rd_c1_arvalid", {31'd0, M_AXI_ARVALID}, 32'd1);
      check("rd_c1_araddr",  {28'd0, M_AXI_ARADDR}, 32'h4);
      step();
      check("rd_c2_rready",  {31'd0, M_AXI_RREADY}, 32'd1);
      check("rd_c2_arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
      step(); step(); step();
      check("rd_c5_rready",    {31'd0, M_AXI_RREADY}, 32'd1);
      check("rd_c5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      drain();
      check("rd_no_timeout", {31'd0, timeout}, 32'd0);
      r_delay = 0;

      // response backpressure with a command waiting
      rdata_cfg = 32'h1234_5678; rresp_cfg = 2'd0; rsp_ready = 1'b0;
      push_exp(1'b0);
      send_cmd(1'b0, 4'hC, 32'h0, 4'h0);
      step(); step();
      push_exp(1'b1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'h3;
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
         check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      check("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      cmd_valid = 1'b0;
      check("bp_next_awvalid", {31'd0, M_AXI_AWVALID}, 32'd1);
      check("bp_next_wstrb",   {28'd0, M_AXI_WSTRB}, 32'h3);
      check("bp_next_busy",    {31'd0, busy}, 32'd1);
      drain();

      // watchdog: AWREADY withheld 20 cycles, DECERR passed through
      aw_delay = 20; bresp_cfg = 2'd3;
      push_exp(1'b1);
      send_cmd(1'b1, 4'h0, 32'h0000_0077, 4'hF);
      repeat (7) step();
      check("wd_c8_timeout", {31'd0, timeout}, 32'd0);
      step();
      check("wd_c9_timeout", {31'd0, timeout}, 32'd1);
      check("wd_c9_awvalid", {31'd0, M_AXI_AWVALID}, 32'd1);
      drain();
      check("wd_sticky", {31'd0, timeout}, 32'd1);
      aw_delay = 0; bresp_cfg = 2'd0; rdata_cfg = 32'h0000_00A1;
      push_exp(1'b0);
      send_cmd(1'b0, 4'h8, 32'h0, 4'h0);
      check("wd_clear_on_accept", {31'd0, timeout}, 32'd0);
      drain();

      // reset while ARVALID is high
      ar_delay = 10;
      send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
      step();
      check("rr_arvalid_before", {31'd0, M_AXI_ARVALID}, 32'd1);
      reset = 1'b1;
      step();
      check("rr_arvalid",   {31'd0, M_AXI_ARVALID}, 32'd0);
      check("rr_busy",      {31'd0, busy}, 32'd0);
      check("rr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      reset = 1'b0;
      step();
      check("rr_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
      repeat (15) step();
      ar_delay = 0;

      // mixed traffic with random slave delays
      for (int i = 0; i < 6; i++) begin
         aw_delay = $urandom_range(3); w_delay = $urandom_range(3); b_delay = $urandom_range(3);
         ar_delay = $urandom_range(3); r_delay = $urandom_range(3);
         rdata_cfg = $urandom; rresp_cfg = 2'($urandom_range(3)); bresp_cfg = 2'($urandom_range(3));
         rw = 1'($urandom_range(1));
         ra = 4'($urandom_range(3) * 4);
         push_exp(rw);
         send_cmd(rw, ra, $urandom, 4'($urandom_range(15)));
         drain();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-lite initiator that turns a simple command/response interface into AXI4-lite read and write transactions. It is the bus-side counterpart of the team's AXI4-lite serial peripheral responder. It lets in-fabric logic (a test sequencer or DMA-lite engine) access the serial IP registers: data, status, control and brd at offsets 0/4/8/12. The block is fully registered, carries one transaction at a time, and includes a sticky watchdog for a stalled slave.

## Interface
- C_M_AXI_ADDR_WIDTH, 4, AXI address width; cmd_addr is passed through unmodified.
- C_TIMEOUT, 255, wait cycles after which `timeout` sets. Range is 1..65535.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  block accepts a command; high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte enables.
- rsp_valid  out  1  response is available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_write  out  1  the response belongs to a write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as captured.
- busy  out  1  state is not IDLE.
- timeout  out  1  sticky watchdog flag.
- M_AXI_AWADDR/AWPROT/AWVALID  out  C_M_AXI_ADDR_WIDTH/3/1;  M_AXI_AWREADY  in  1.
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1;  M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1.
- M_AXI_ARADDR/ARPROT/ARVALID  out  C_M_AXI_ADDR_WIDTH/3/1;  M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  32;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1.

## Operation
- States and transitions:
  - IDLE: on cmd_valid&&cmd_ready, latch addr/wdata/wstrb/write. Go to WR_ADDRDATA if cmd_write, else RD_ADDR.
  - WR_ADDRDATA: AWVALID and WVALID are independent registered flags, both set on entry. Each clears on the edge where its own VALID&&READY is sampled. Once both handshakes are done (same or different cycles), go to WR_RESP.
  - WR_RESP: BREADY=1. On BVALID, capture BRESP into rsp_resp, set rsp_write=1 and rsp_rdata=0, go to RESP.
  - RD_ADDR: ARVALID=1 until ARREADY is sampled, then go to RD_DATA.
  - RD_DATA: RREADY=1. On RVALID, capture RDATA/RRESP and set rsp_write=0, go to RESP.
  - RESP: rsp_valid=1 with stable payload until rsp_ready; then go to IDLE.
- AWADDR, ARADDR, WDATA and WSTRB hold the latched command values and are stable while the matching VALID is high. AWPROT and ARPROT are constant 3'b000.
- Once asserted, a VALID is never withdrawn before its READY, per AXI.
- SLVERR/DECERR responses are passed through in rsp_resp and are not retried.
- Watchdog:
  - A 16-bit counter clears on command accept and increments in every non-IDLE, non-RESP state where the awaited handshake has not occurred.
  - When the counter reaches C_TIMEOUT, `timeout` sets. It stays set until the next command accept or reset.
  - The transaction continues waiting; nothing is aborted. The counter saturates.
- Reset (any state, including mid-transaction): on the next edge, state goes to IDLE and all outputs go to 0. This means cmd_ready=0 in that cycle; cmd_ready=1 from the first cycle after reset deasserts. Latched command and response are discarded.

## Timing
- Every output is registered, with no combinational path from any input to any output.
- cmd_ready is high only in IDLE, so a new command is never accepted in the RESP-exit cycle.
- Minimum write latency:
  - Accept at edge 0; AWVALID/WVALID high in cycle 1.
  - With same-cycle ready, both handshakes complete at edge 1 and BREADY is high in cycle 2.
  - With BVALID in cycle 2, rsp_valid is high in cycle 3.
- Minimum read latency: accept at edge 0; ARVALID in cycle 1; RREADY in cycle 2; rsp_valid in cycle 3.
- Against the codebase responder:
  - Writes: AWREADY/WREADY arrive one cycle after both valids; BVALID follows one cycle later.
  - Reads: ARREADY arrives one cycle after ARVALID; RVALID follows one cycle later.
  - The master tolerates any of these gaps, and RVALID/BVALID arriving before RREADY/BREADY rise.
- Back-to-back: the earliest next accept is the cycle after rsp_valid&&rsp_ready.

## Test plan
- Write with zero-wait slave: cmd write addr=0x8, wdata=0x0000_0005, wstrb=0xF -> AWVALID/WVALID in cycle 1 with AWADDR=0x8; rsp_valid in cycle 3 with rsp_write=1, rsp_resp=0.
- Skewed write handshakes: WREADY 3 cycles after AWREADY -> AWVALID drops after its handshake; WVALID holds 0x5 until WREADY; exactly one B accepted; single response.
- Read with 4 wait states on RVALID: addr=0x4, RDATA=0xE000_0003, RRESP=2 -> RREADY held; rsp_rdata=0xE000_0003, rsp_resp=2, rsp_write=0.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_valid and payload stable; cmd_ready=0 throughout; cmd accepted the cycle after release.
- Watchdog: C_TIMEOUT=8 with AWREADY withheld 20 cycles -> timeout=1 after cycle 8, AWVALID still high, completion normal; timeout clears on the next accept.
- Reset mid-read while ARVALID is high -> the next edge sees ARVALID=0 and busy=0; cmd_ready=1 after reset deasserts; no rsp_valid is issued.
